// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scanner: bus address map, ctrl bit
// positions and the a..g glyph table (1 = segment lit).
package seg7_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA_LO = 2'd0,
    ADDR_DATA_HI = 2'd1,
    ADDR_CTRL    = 2'd2,
    ADDR_DP      = 2'd3
  } seg_addr_e;

  localparam int CTRL_MODE_BIT  = 8;
  localparam int CTRL_BLANK_BIT = 9;

  localparam logic [6:0] GLYPH_0 = 7'b1111110;
  localparam logic [6:0] GLYPH_1 = 7'b0110000;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'b1111110;
      4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;
      4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;
      4'h5: g = 7'b1011011;
      4'h6: g = 7'b1011111;
      4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1111011;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b0011111;
      4'hC: g = 7'b1001110;
      4'hD: g = 7'b0111101;
      4'hE: g = 7'b1001111;
      4'hF: g = 7'b1000111;
      default: g = 7'b0000000;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational glyph lookup for one digit: hex nibble, or the 0/1 glyph of
// bit 0 when binary mode is selected.
module seg7_decode (
  input  logic [3:0] nibble,
  input  logic       mode,
  output logic [6:0] glyph
);
  import seg7_pkg::*;

  // Glyph selection by display mode
  always_comb begin
    glyph = 7'b0000000;
    if (mode) begin
      glyph = nibble[0] ? GLYPH_1 : GLYPH_0;
    end else begin
      glyph = hex_glyph(nibble);
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Bus-mapped N-digit seven-segment scanner: register file, prescaler, digit
// index, leading-zero blanking and registered active-low digit/segment drives.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000,
  parameter int CNT_W      = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  seg_cs,
  input  logic                  seg_write,
  input  logic                  seg_read,
  input  logic [1:0]            seg_addr,
  input  logic [15:0]           seg_wdata,
  output logic [15:0]           seg_rdata,
  output logic [NUM_DIGITS-1:0] dig_n,
  output logic [7:0]            seg_n
);
  import seg7_pkg::*;

  localparam logic [8:0]       ONE_9    = 9'd1;
  localparam logic [7:0]       DIG_MASK = 8'((ONE_9 << NUM_DIGITS) - ONE_9);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);

  logic [31:0]           data_r;
  logic [7:0]            enable_r;
  logic                  mode_r;
  logic                  blank_r;
  logic [7:0]            dp_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [2:0]            idx_r;
  logic [NUM_DIGITS-1:0] dig_n_r;
  logic [7:0]            seg_n_r;

  logic                  wr_en_s;
  logic                  tc_s;
  logic [15:0]           rdata_s;
  logic [NUM_DIGITS-1:0] sel_s;
  logic [3:0]            nibble_s;
  logic [6:0]            glyph_s;
  logic                  upper_nz_s;
  logic                  blank_s;
  logic                  lit_s;

  assign wr_en_s   = seg_cs & seg_write;
  assign tc_s      = (cnt_r == CNT_LAST);
  assign seg_rdata = rdata_s;
  assign dig_n     = dig_n_r;
  assign seg_n     = seg_n_r;

  // Software-visible register file; mask bits beyond the digit count are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r   <= 32'h0000_0000;
      enable_r <= DIG_MASK;
      mode_r   <= 1'b0;
      blank_r  <= 1'b0;
      dp_r     <= 8'h00;
    end else if (wr_en_s) begin
      case (seg_addr_e'(seg_addr))
        ADDR_DATA_LO: data_r[15:0]  <= seg_wdata;
        ADDR_DATA_HI: data_r[31:16] <= seg_wdata;
        ADDR_CTRL: begin
          enable_r <= seg_wdata[7:0] & DIG_MASK;
          mode_r   <= seg_wdata[CTRL_MODE_BIT];
          blank_r  <= seg_wdata[CTRL_BLANK_BIT];
        end
        ADDR_DP:      dp_r <= seg_wdata[7:0] & DIG_MASK;
        default:      data_r <= data_r;
      endcase
    end
  end

  // Combinational read-back mux
  always_comb begin
    rdata_s = 16'h0000;
    if (seg_cs && seg_read) begin
      case (seg_addr_e'(seg_addr))
        ADDR_DATA_LO: rdata_s = data_r[15:0];
        ADDR_DATA_HI: rdata_s = data_r[31:16];
        ADDR_CTRL:    rdata_s = {6'b000000, blank_r, mode_r, enable_r};
        ADDR_DP:      rdata_s = {8'h00, dp_r};
        default:      rdata_s = 16'h0000;
      endcase
    end else begin
      rdata_s = 16'h0000;
    end
  end

  // Prescaler and digit index; a disabled digit still uses its full slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
      idx_r <= 3'd0;
    end else if (tc_s) begin
      cnt_r <= {CNT_W{1'b0}};
      idx_r <= (idx_r == IDX_LAST) ? 3'd0 : idx_r + 3'd1;
    end else begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Current digit: one-hot select, nibble, and leading-zero blanking
  always_comb begin
    sel_s      = {NUM_DIGITS{1'b0}};
    upper_nz_s = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      sel_s[i]   = (idx_r == 3'(i));
      upper_nz_s = upper_nz_s | ((3'(i) >= idx_r) && (data_r[i*4 +: 4] != 4'h0));
    end
    nibble_s = mode_r ? {3'b000, data_r[idx_r]} : data_r[{idx_r, 2'b00} +: 4];
    blank_s  = blank_r & ~mode_r & (idx_r != 3'd0) & ~upper_nz_s;
    lit_s    = enable_r[idx_r] & ~blank_s;
  end

  seg7_decode u_decode (
    .nibble (nibble_s),
    .mode   (mode_r),
    .glyph  (glyph_s)
  );

  // Registered active-low drives, one cycle behind the index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_n_r <= {NUM_DIGITS{1'b1}};
      seg_n_r <= 8'hFF;
    end else if (lit_s) begin
      dig_n_r <= ~sel_s;
      seg_n_r <= {~dp_r[idx_r], ~glyph_s};
    end else begin
      dig_n_r <= {NUM_DIGITS{1'b1}};
      seg_n_r <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench: stimulus queues expected outputs/read data by cycle, a
// negedge monitor pops and compares. Second instance is a 3-digit SCAN_DIV=1 build.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        seg_cs = 1'b0;
  logic        seg_write = 1'b0;
  logic        seg_read = 1'b0;
  logic [1:0]  seg_addr = 2'd0;
  logic [15:0] seg_wdata = 16'h0000;
  logic [15:0] rdata0, rdata1;
  logic [7:0]  dig_n0, seg_n0, seg_n1;
  logic [2:0]  dig_n1;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int next_id = 0;

  typedef struct {
    int          due;
    int          kind;   // 0 main out, 1 main read, 2 small out, 3 small read
    logic [15:0] exp_a;
    logic [7:0]  exp_s;
    bit          chk_dig;
    int          id;
  } sb_item_t;

  sb_item_t sb_q[$];
  sb_item_t it;

  seg7_scan_ctrl #(.NUM_DIGITS(8), .SCAN_DIV(4), .CNT_W(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .seg_cs(seg_cs), .seg_write(seg_write),
    .seg_read(seg_read), .seg_addr(seg_addr), .seg_wdata(seg_wdata),
    .seg_rdata(rdata0), .dig_n(dig_n0), .seg_n(seg_n0)
  );

  seg7_scan_ctrl #(.NUM_DIGITS(3), .SCAN_DIV(1), .CNT_W(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .seg_cs(seg_cs), .seg_write(seg_write),
    .seg_read(seg_read), .seg_addr(seg_addr), .seg_wdata(seg_wdata),
    .seg_rdata(rdata1), .dig_n(dig_n1), .seg_n(seg_n1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every scoreboard entry due in this cycle
  always @(negedge clk) begin
    logic [15:0] act_a;
    logic [7:0]  act_s;
    bit          ok;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      it = sb_q.pop_front();
      act_s = 8'h00;
      case (it.kind)
        0: begin act_a = {8'h00, dig_n0}; act_s = seg_n0; end
        1: act_a = rdata0;
        2: begin act_a = {13'h0000, dig_n1}; act_s = seg_n1; end
        default: act_a = rdata1;
      endcase
      ok = (it.due == cyc);
      if (it.kind == 0 || it.kind == 2) begin
        if (it.chk_dig && act_a != it.exp_a) ok = 1'b0;
        if (act_s != it.exp_s) ok = 1'b0;
      end else if (act_a != it.exp_a) begin
        ok = 1'b0;
      end
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL chk%0d kind%0d cyc%0d(due %0d): got dig/rd=%h seg=%h, expected dig/rd=%h seg=%h",
                 it.id, it.kind, cyc, it.due, act_a, act_s, it.exp_a, it.exp_s);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input int due, input int kind, input logic [15:0] a,
                      input logic [7:0] s, input bit chk_dig);
    sb_item_t x;
    x.due = due; x.kind = kind; x.exp_a = a; x.exp_s = s;
    x.chk_dig = chk_dig; x.id = next_id;
    next_id++;
    sb_q.push_back(x);
  endtask

  task automatic wait_cyc(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    seg_cs = 1'b1; seg_write = 1'b1; seg_addr = a; seg_wdata = d;
    @(posedge clk); #1;
    seg_cs = 1'b0; seg_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [15:0] e0, input logic [15:0] e1);
    seg_cs = 1'b1; seg_read = 1'b1; seg_addr = a;
    push(cyc, 1, e0, 8'h00, 1'b0);
    push(cyc, 3, e1, 8'h00, 1'b0);
    @(posedge clk); #1;
    seg_cs = 1'b0; seg_read = 1'b0;
  endtask

  // Scan timing after the final reset release (after posedge 12): edge e shows digit ((e-13)/4)%8
  function automatic int slot_start(input int d, input int min_e);
    for (int e = min_e; e < min_e + 40; e++)
      if ((e - 13) % 4 == 0 && ((e - 13) / 4) % 8 == d) return e;
    return min_e;
  endfunction

  function automatic logic [15:0] dsel(input int d);
    logic [7:0] v;
    v = 8'd1 << d;
    return {8'h00, ~v};
  endfunction

  initial begin
    int s0, t;
    logic [2:0] v3;

    // Reset, release after edge 2, then async reset mid-scan
    wait_cyc(2);
    rst_n = 1'b1;
    push(9, 0, dsel(1), 8'h81, 1'b1);
    wait_cyc(10);
    push(10, 0, 16'h00FF, 8'hFF, 1'b1);
    push(10, 2, 16'h0007, 8'hFF, 1'b1);
    rst_n = 1'b0;
    wait_cyc(12);
    rst_n = 1'b1;
    wait_cyc(13);
    push(13, 0, dsel(0), 8'h81, 1'b1);
    rd(2'd2, 16'h00FF, 16'h0007);

    // Hex data: digit 0 '4' for a full slot, then digit 1 '3', then frame wrap
    wr(2'd0, 16'h1234);
    wr(2'd1, 16'h5678);
    rd(2'd0, 16'h1234, 16'h1234);
    rd(2'd1, 16'h5678, 16'h5678);
    s0 = slot_start(0, cyc + 1);
    for (int k = 0; k < 4; k++) push(s0 + k, 0, dsel(0), 8'hCC, 1'b1);
    push(s0 + 4, 0, dsel(1), 8'h86, 1'b1);
    push(s0 + 32, 0, dsel(0), 8'hCC, 1'b1);
    wait_cyc(s0 + 33);

    // Binary mode: data bits 0 and 2 set
    wr(2'd2, 16'h01FF);
    wr(2'd0, 16'h0005);
    wr(2'd1, 16'h0000);
    s0 = slot_start(0, cyc + 1);
    for (int d = 0; d < 8; d++)
      push(s0 + 4*d, 0, dsel(d), (d == 0 || d == 2) ? 8'hCF : 8'h81, 1'b1);
    wait_cyc(s0 + 29);

    // Leading-zero blanking: all zero, then nibble 2 = 1
    wr(2'd2, 16'h02FF);
    wr(2'd0, 16'h0000);
    s0 = slot_start(0, cyc + 1);
    push(s0, 0, dsel(0), 8'h81, 1'b1);
    for (int d = 1; d < 8; d++) push(s0 + 4*d, 0, 16'h0000, 8'hFF, 1'b0);
    wait_cyc(s0 + 29);
    wr(2'd0, 16'h0100);
    s0 = slot_start(0, cyc + 1);
    for (int d = 0; d < 8; d++) begin
      if (d < 2)       push(s0 + 4*d, 0, dsel(d), 8'h81, 1'b1);
      else if (d == 2) push(s0 + 4*d, 0, dsel(d), 8'hCF, 1'b1);
      else             push(s0 + 4*d, 0, 16'h0000, 8'hFF, 1'b0);
    end
    wait_cyc(s0 + 29);

    // Enable mask and decimal point
    wr(2'd2, 16'h000F);
    wr(2'd3, 16'h0001);
    wr(2'd0, 16'h0000);
    rd(2'd2, 16'h000F, 16'h0007);
    rd(2'd3, 16'h0001, 16'h0001);
    s0 = slot_start(0, cyc + 1);
    for (int d = 0; d < 8; d++) begin
      if (d == 0)     push(s0, 0, dsel(0), 8'h01, 1'b1);
      else if (d < 4) push(s0 + 4*d, 0, dsel(d), 8'h81, 1'b1);
      else            push(s0 + 4*d, 0, 16'h00FF, 8'hFF, 1'b1);
    end
    wait_cyc(s0 + 29);

    // Write sampled on the terminal-count edge leaving digit 0
    t = cyc + 2;
    while (!((t - 13) % 4 == 3 && ((t - 13) / 4) % 8 == 0)) t++;
    wait_cyc(t - 1);
    wr(2'd0, 16'h00A0);
    push(t, 0, dsel(0), 8'h01, 1'b1);
    push(t + 1, 0, dsel(1), 8'h88, 1'b1);
    for (int e = t + 2; e <= t + 4; e++) begin
      v3 = 3'd1 << ((e - 13) % 3);
      push(e, 2, {13'h0000, ~v3}, ((e - 13) % 3 == 0) ? 8'h01 :
                                  ((e - 13) % 3 == 1) ? 8'h88 : 8'h81, 1'b1);
    end
    wait_cyc(t + 5);

    // Write strobe without chip select is ignored
    seg_cs = 1'b0; seg_write = 1'b1; seg_addr = 2'd3; seg_wdata = 16'h00FF;
    @(posedge clk); #1;
    seg_write = 1'b0;
    rd(2'd3, 16'h0001, 16'h0001);
    rd(2'd0, 16'h00A0, 16'h00A0);
    wait_cyc(cyc + 3);

    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
